// File: rtl/my_rr_arbiter8.sv
// Round-robin arbiter for eight requesters sharing one my_dmux8way resource.
// Grants are held until done, request drop or the MAX_HOLD limit, with an idle bubble between grants.
module my_rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned HOLD_W   = 8
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] req_i,
    input  logic       done_i,
    output logic [7:0] grant_o,
    output logic [2:0] sel_o,
    output logic       busy_o,
    output logic       timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01
    } state_t;

    localparam bit                HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = {HOLD_W{1'b1}};

    state_t            state_q, state_d;
    logic [7:0]        grant_q, grant_d;
    logic [2:0]        sel_q, sel_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;
    logic [HOLD_W-1:0] count_q, count_d;
    logic [2:0]        last_q, last_d;

    logic              pick_valid_s;
    logic [2:0]        pick_idx_s;
    logic [2:0]        scan_idx_s;
    logic              owner_req_s;
    logic              hold_hit_s;

    // Winner search: scan downward from last+8 (= last) to last+1 so the nearest requester wins.
    always_comb begin
        pick_valid_s = |req_i;
        pick_idx_s   = 3'd0;
        scan_idx_s   = 3'd0;
        for (int k = 8; k >= 1; k--) begin
            scan_idx_s = last_q + 3'(k);
            if (req_i[scan_idx_s]) begin
                pick_idx_s = scan_idx_s;
            end else begin
                pick_idx_s = pick_idx_s;
            end
        end
    end

    // Next-state and output decode for the IDLE/GRANT controller.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        sel_d       = sel_q;
        busy_d      = busy_q;
        timeout_d   = 1'b0;
        count_d     = count_q;
        last_d      = last_q;
        owner_req_s = req_i[sel_q];
        hold_hit_s  = HOLD_EN && (count_q == HOLD_LAST);
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_d = ST_GRANT;
                    grant_d = 8'd1 << pick_idx_s;
                    sel_d   = pick_idx_s;
                    busy_d  = 1'b1;
                    count_d = '0;
                end else begin
                    grant_d = 8'd0;
                    busy_d  = 1'b0;
                end
            end
            ST_GRANT: begin
                if (done_i || !owner_req_s || hold_hit_s) begin
                    state_d   = ST_IDLE;
                    grant_d   = 8'd0;
                    busy_d    = 1'b0;
                    last_d    = sel_q;
                    // Timeout flags only a revocation the owner did not ask for.
                    timeout_d = hold_hit_s && !done_i && owner_req_s;
                end else if (count_q != HOLD_MAX) begin
                    count_d = count_q + HOLD_W'(1);
                end else begin
                    count_d = count_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 8'd0;
                busy_d  = 1'b0;
                count_d = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            grant_q   <= 8'd0;
            sel_q     <= 3'd0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            count_q   <= '0;
            last_q    <= 3'd7;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            count_q   <= count_d;
            last_q    <= last_d;
        end
    end

    assign grant_o   = grant_q;
    assign sel_o     = sel_q;
    assign busy_o    = busy_q;
    assign timeout_o = timeout_q;

endmodule
